// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register, so the next sample
// can be accepted while the current one shifts out, plus an optional idle gap between words.
//
// state | meaning
// IDLE  | no word in flight, outputs low, waiting for hold to fill
// SHIFT | presenting bit count n of the current word on bit_out
// GAP   | GAP_BITS idle bit periods after a word, bit_out held low
module bit_serializer #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int GAP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             bit_out,
  output logic             frame_out,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;

  logic             hold_first;
  logic [WIDTH-1:0] hold_adv;
  logic             shreg_bit;
  logic [WIDTH-1:0] shreg_adv;
  logic             load_point;
  logic             do_load;

  assign s_ready = !hold_full;

  // The shifter holds only the bits still to be sent, so the next bit is always at one end.
  always_comb begin
    hold_first = (MSB_FIRST != 0) ? hold[WIDTH-1]  : hold[0];
    hold_adv   = (MSB_FIRST != 0) ? (hold << 1)    : (hold >> 1);
    shreg_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    shreg_adv  = (MSB_FIRST != 0) ? (shreg << 1)   : (shreg >> 1);
    load_point = (state == IDLE) ||
                 ((state == SHIFT) && (cnt == LAST_CNT) && (GAP_BITS == 0)) ||
                 ((state == GAP) && (gcnt == 4'd0));
    do_load    = load_point && hold_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= 4'd0;
      bit_out   <= 1'b0;
      frame_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Accept and load are exclusive: loading needs hold_full, accepting needs it clear.
      if (s_valid && !hold_full) begin
        hold      <= s_data;
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end

      if (do_load) begin
        state     <= SHIFT;
        shreg     <= hold_adv;
        cnt       <= '0;
        bit_out   <= hold_first;
        frame_out <= 1'b1;
        busy      <= 1'b1;
      end else if (load_point) begin
        state     <= IDLE;
        cnt       <= '0;
        bit_out   <= 1'b0;
        frame_out <= 1'b0;
        busy      <= 1'b0;
      end else if (state == SHIFT) begin
        frame_out <= 1'b0;
        if (cnt == LAST_CNT) begin
          state   <= GAP;
          gcnt    <= GAP_LOAD;
          bit_out <= 1'b0;
        end else begin
          cnt     <= cnt + 1'b1;
          shreg   <= shreg_adv;
          bit_out <= shreg_bit;
        end
      end else begin
        gcnt <= gcnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed and randomized checks of bit_serializer in three 8-bit configurations:
// MSB-first with one gap bit, LSB-first with two gap bits, MSB-first contiguous.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0, b_data = '0, c_data = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic       a_ready, a_bit, a_frame, a_busy;
  logic       b_ready, b_bit, b_frame, b_busy;
  logic       c_ready, c_bit, c_frame, c_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .bit_out(a_bit), .frame_out(a_frame), .busy(a_busy));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .bit_out(b_bit), .frame_out(b_frame), .busy(b_busy));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_BITS(0)) u_c (
    .clk(clk), .rst(rst), .s_data(c_data), .s_valid(c_valid), .s_ready(c_ready),
    .bit_out(c_bit), .frame_out(c_frame), .busy(c_busy));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One word through u_a: checks latency, all 8 bits with frame, the single gap bit, idle.
  task automatic send_a(input logic [7:0] w, input string tag);
    a_data  = w;
    a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    check_val($sformatf("%s_held_busy", tag), a_busy, 0);
    check_val($sformatf("%s_held_ready", tag), a_ready, 0);
    tick;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("%s_bit%0d", tag, i), {a_busy, a_frame, a_bit},
                {1'b1, (i == 0), w[7-i]});
      tick;
    end
    check_val($sformatf("%s_gap", tag), {a_busy, a_frame, a_bit}, 3'b100);
    tick;
    check_val($sformatf("%s_idle", tag), {a_busy, a_frame, a_bit}, 3'b000);
  endtask

  // Reference for the randomized run on u_b (LSB first, 2 gap bits).
  int         phase = 0;
  int         nbit  = 0;
  int         ngap  = 0;
  int         cyc   = 0;
  logic [7:0] cur   = '0;
  logic [7:0] q[$];

  task automatic mon_b;
    logic [2:0] exp3;
    exp3 = 3'b000;
    case (phase)
      0: if (q.size() > 0) begin
           cur   = q.pop_front();
           exp3  = {2'b11, cur[0]};
           nbit  = 1;
           phase = 1;
         end
      1: begin
           exp3 = {2'b10, cur[nbit]};
           nbit++;
           if (nbit == 8) begin
             phase = 2;
             ngap  = 0;
           end
         end
      default: begin
        exp3 = 3'b100;
        ngap++;
        if (ngap == 2) phase = 0;
      end
    endcase
    check_val($sformatf("rnd_c%0d", cyc), {b_busy, b_frame, b_bit}, exp3);
  endtask

  initial begin
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic [15:0] pair;
    logic        acc;
    logic [7:0]  accd;
    int          widx;
    int          acc_cnt;

    // Reset takes effect with no clock edge
    #2 rst = 1'b0;
    #1;
    check_val("rst_a", {a_ready, a_busy, a_frame, a_bit}, 4'b1000);
    check_val("rst_b", {b_ready, b_busy, b_frame, b_bit}, 4'b1000);
    check_val("rst_c", {c_ready, c_busy, c_frame, c_bit}, 4'b1000);
    tick;
    tick;
    rst = 1'b1;
    tick;

    send_a(8'hA5, "a5");

    // LSB first, 0x01, two gap bits
    b_data  = 8'h01;
    b_valid = 1'b1;
    tick;
    b_valid = 1'b0;
    check_val("lsb_held_busy", b_busy, 0);
    tick;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("lsb_bit%0d", i), {b_busy, b_frame, b_bit},
                {1'b1, (i == 0), (i == 0)});
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("lsb_gap%0d", i), {b_busy, b_frame, b_bit}, 3'b100);
      tick;
    end
    check_val("lsb_idle", {b_busy, b_frame, b_bit}, 3'b000);

    // Contiguous 0xFF then 0x00
    pair    = 16'hFF00;
    c_data  = 8'hFF;
    c_valid = 1'b1;
    tick;
    c_data = 8'h00;
    check_val("b2b_ready0", c_ready, 0);
    tick;
    for (int j = 0; j < 16; j++) begin
      if (j == 1) begin
        c_valid = 1'b0;
        check_val("b2b_held_ready", c_ready, 0);
      end
      check_val($sformatf("b2b_bit%0d", j), {c_busy, c_frame, c_bit},
                {1'b1, (j == 0 || j == 8), pair[15-j]});
      tick;
    end
    check_val("b2b_idle", {c_busy, c_frame, c_bit}, 3'b000);

    // Backpressure: three words with s_valid held high
    words   = '{8'h11, 8'h22, 8'h33};
    stream  = 24'h112233;
    widx    = 0;
    c_valid = 1'b1;
    c_data  = words[0];
    for (int c = 1; c <= 26; c++) begin
      acc = c_valid && c_ready;
      tick;
      if (acc) begin
        widx++;
        if (widx == 3) c_valid = 1'b0;
        else c_data = words[widx];
      end
      check_val($sformatf("bp_ready_c%0d", c), c_ready, (c == 2 || c == 10 || c >= 18));
      if (c >= 2 && c <= 25)
        check_val($sformatf("bp_bit_c%0d", c), {c_busy, c_frame, c_bit},
                  {1'b1, (c == 2 || c == 10 || c == 18), stream[23-(c-2)]});
      else if (c == 26)
        check_val("bp_idle", {c_busy, c_frame, c_bit}, 3'b000);
    end

    // Reset after three bits of 0xA5 with 0x77 waiting in hold
    a_data  = 8'hA5;
    a_valid = 1'b1;
    tick;
    a_data = 8'h77;
    tick;
    tick;
    a_valid = 1'b0;
    tick;
    check_val("mid_bit2", {a_busy, a_frame, a_bit}, 3'b101);
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_now", {a_ready, a_busy, a_frame, a_bit}, 4'b1000);
    tick;
    check_val("mid_rst_held", {a_ready, a_busy, a_frame, a_bit}, 4'b1000);
    rst = 1'b1;
    tick;
    tick;
    check_val("mid_no_resume", {a_ready, a_busy, a_frame, a_bit}, 4'b1000);
    send_a(8'h3C, "3c");

    // Randomized traffic on u_b
    acc_cnt = 0;
    phase   = 0;
    while (acc_cnt < 1000 && cyc < 30000) begin
      b_valid = ($urandom_range(0, 2) != 0);
      b_data  = 8'($urandom);
      acc     = b_valid && b_ready;
      accd    = b_data;
      tick;
      cyc++;
      mon_b;
      if (acc) begin
        q.push_back(accd);
        acc_cnt++;
      end
    end
    check_val("rnd_words", acc_cnt, 1000);
    b_valid = 1'b0;
    repeat (30) begin
      tick;
      cyc++;
      mon_b;
    end
    check_val("rnd_drain_q", q.size(), 0);
    check_val("rnd_drain_phase", phase, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving bits per sample; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = MSB transmitted first, 0 = LSB first.
REQ-003 The block SHALL have parameter GAP_BITS, default 1: idle bit periods between words; legal range 0..15.
REQ-004 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port s_data  input  WIDTH  parallel sample word.
REQ-007 The block SHALL have port s_valid  input  1  s_data is valid.
REQ-008 The block SHALL have port s_ready  output  1  holding register empty; word accepted when s_valid && s_ready at a rising edge.
REQ-009 The block SHALL have port bit_out  output  1  registered serial data, one bit per clk.
REQ-010 The block SHALL have port frame_out  output  1  registered, high only during the first bit of each word.
REQ-011 The block SHALL have port busy  output  1  high while a word is shifting or in a gap.

Function
REQ-012 The block SHALL contain two word stages: a holding register (hold, hold_full) and a shift register, so one word can be accepted while another shifts.
REQ-013 s_ready SHALL equal !hold_full combinationally; s_data SHALL be sampled only on an accepting edge.
REQ-014 The FSM SHALL have states IDLE, SHIFT and GAP; busy SHALL be 1 in SHIFT and GAP, 0 in IDLE.
REQ-015 IDLE: when hold_full=1 at a rising edge, the FSM SHALL load hold into the shifter, clear hold_full, reset the bit counter to 0 and enter SHIFT.
REQ-016 Latency: for a word accepted at edge k with the FSM in IDLE, the first bit SHALL appear on bit_out, with frame_out=1, for the cycle following edge k+1.
REQ-017 SHIFT: bit_out SHALL present bit WIDTH-1-n (MSB_FIRST=1) or bit n (MSB_FIRST=0) during count n, n = 0..WIDTH-1, one bit per cycle with no stalls.
REQ-018 At the edge ending bit WIDTH-1: with GAP_BITS>0 the FSM SHALL enter GAP; with GAP_BITS=0 it SHALL load hold directly if hold_full=1 (contiguous stream), else enter IDLE.
REQ-019 GAP SHALL last exactly GAP_BITS cycles with bit_out=0 and frame_out=0, then follow the IDLE loading rule at the same edge.
REQ-020 In IDLE, bit_out and frame_out SHALL be 0.
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits wide; the gap counter SHALL be 4 bits wide.
REQ-022 A word that frees hold at an edge SHALL NOT be replaced at that same edge, because s_ready was 0 before that edge; s_ready SHALL return to 1 in the following cycle.
REQ-023 With s_valid held high, GAP_BITS=0 and WIDTH>=2, output SHALL be gap-free indefinitely.
REQ-024 s_valid deasserting without acceptance SHALL have no effect on state.

Reset
REQ-025 While rst=0, the block SHALL set the FSM to IDLE, counters to 0, hold_full=0, shift register to 0, bit_out=0, frame_out=0 and busy=0 immediately, without waiting for clk.
REQ-026 s_ready SHALL read 1 during and after reset.
REQ-027 Reset mid-word SHALL discard the in-flight word and the held word; no partial word SHALL resume after reset.
REQ-028 Reset release SHALL take effect at the first rising edge with rst=1.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, GAP_BITS=1; accept 0xA5 -> bit_out 1,0,1,0,0,1,0,1; frame_out=1 on the first bit only; one 0 gap bit; then busy=0.
REQ-030 MSB_FIRST=0, WIDTH=8; accept 0x01 -> bit_out 1,0,0,0,0,0,0,0.
REQ-031 GAP_BITS=0, WIDTH=8; 0xFF then 0x00 offered back-to-back -> 16 contiguous bits (8 ones, 8 zeros); frame_out at bit 0 and bit 8; busy never drops between words.
REQ-032 Backpressure: three words offered with s_valid held high -> word 2 is held; s_ready=0 while hold_full=1; word 3 is accepted the cycle after word 2 loads; order is preserved.
REQ-033 Reset mid-word: rst=0 after 3 bits of 0xA5 -> bit_out=0, frame_out=0, busy=0, s_ready=1 immediately; next word 0x3C transmits fully and correctly.
REQ-034 The bench SHALL run randomized s_valid/s_data for 1000 words against a reference model and check every bit, frame_out position and gap length.
